regfile_read_stage: RTL and testbench
=====================================

// Module: regfile_read_stage
// PURPOSE
//  Consumer end of the writeback interface: holds the architectural register file and accepts
//  writeback's data_writeReg/ctrl_writeReg and data_writeStatusReg each cycle.
//  Serves two decode-stage read ports and registers the operands, plus the instruction,
//  into the D/X pipeline latch. Provides write-to-read bypass, stall hold and flush-to-bubble.
// PARAMETERS
//  DATA_W      32  register/operand width
//  NUM_REGS    32  architectural registers; address width = $clog2(NUM_REGS) = 5
//  STATUS_REG  30  index of rstatus, the target of the status write port
//  ZERO_REG    0   hardwired-zero register index
// PORTS
//  clock                input   1   single clock, rising edge
//  ctrl_reset_n         input   1   asynchronous, active-low reset
//  ctrl_writeEnable     input   1   writeback register write strobe
//  ctrl_writeReg        input   5   writeback destination index
//  data_writeReg        input   32  writeback data
//  ctrl_writeStatus     input   1   writeback rstatus write strobe
//  data_writeStatusReg  input   32  rstatus data (exception flag or setx target)
//  ctrl_readRegA        input   5   decode source A index
//  ctrl_readRegB        input   5   decode source B index
//  insn_in              input   32  decode instruction
//  stall                input   1   hold the D/X latch
//  flush                input   1   load a bubble into the D/X latch
//  data_readRegA        output  32  latched operand A
//  data_readRegB        output  32  latched operand B
//  insn_out             output  32  latched instruction
//  valid_out            output  1   latch holds a real instruction
// BEHAVIOUR
//  - Reset (async assert, sync release): r0..r31 = 0, all outputs = 0, valid_out = 0.
//  - Writes commit on the rising edge.
//    - ctrl_writeEnable && ctrl_writeReg != 0 -> reg[ctrl_writeReg] <= data_writeReg.
//    - ctrl_writeStatus -> reg[30] <= data_writeStatusReg.
//    - Both strobes targeting r30 in the same cycle: the status port wins.
//  - r0 always reads 0. Writes to r0 are dropped.
//  - Read is combinational from storage, with bypass.
//    - If a strobe in the same cycle targets the read index (non-zero), the read returns
//      the incoming data, not the stored value.
//    - The status-port bypass takes priority over the normal-port bypass for r30.
//  - D/X latch, 1-cycle latency from index to data_readRegX; priority: reset > flush > stall > load.
//    - flush: insn_out = 32'h0 (nop), data_readRegA/B = 0, valid_out = 0.
//    - stall (no flush): all latch outputs hold.
//    - Register writes still commit during a stall.
//    - Latched operands are not refreshed during a stall. The hazard unit must not stall
//      across a dependent writeback; a held operand stays stale by design.
//    - load: latch the bypassed read data, insn_in, and valid_out = 1.
//  - Indices are 5-bit and never out of range. No X propagation from unwritten regs (all are reset).
//  - Reset asserted mid-operation clears storage and the latch immediately.
//    Any write strobed in that cycle is lost.
// STRUCTURE
//  - Package regfile_pkg: REG_ZERO = 5'd0, REG_STATUS = 5'd30, REG_LINK = 5'd31,
//    INSN_NOP = 32'h0, DATA_W, and ADDR_W.
//  - Sub-module regfile_core: storage, the two write ports with r0 and r30 priority rules,
//    and two bypassed combinational read ports.
//  - Top level: regfile_core plus the D/X latch with flush/stall control.
// TESTING
//  - Reset: pulse ctrl_reset_n low mid-cycle -> all outputs 0 immediately.
//    Then read r1..r31 -> every value is 0.
//  - Write/read: write r5 = 32'hDEADBEEF, then next cycle read A = r5 -> one cycle later
//    data_readRegA = 32'hDEADBEEF and valid_out = 1.
//  - Bypass: in the same cycle write r7 = 32'h12345678 and read B = r7 ->
//    next edge data_readRegB = 32'h12345678.
//  - r0 and status: write r0 = 32'hFFFFFFFF -> r0 reads 0.
//    Same cycle, normal write r30 = 32'h5 and status write = 32'h1 -> r30 reads 32'h1.
//  - Stall/flush: load insn 32'hABCD0001, then stall for 2 cycles while insn_in changes ->
//    outputs hold. Assert flush and stall together -> insn_out = 0, valid_out = 0.
//  - Stall-write: stall, and during the stall write r9 = 32'h99 -> the latch holds.
//    After release, a read of r9 returns 32'h99.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the decode-side register file and D/X pipeline latch.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    localparam logic [ADDR_W-1:0] REG_ZERO   = 5'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS = 5'd30;
    localparam logic [ADDR_W-1:0] REG_LINK   = 5'd31;

    localparam logic [DATA_W-1:0] INSN_NOP   = 32'h0;

endpackage

// File: rtl/regfile_core.sv
// Architectural register file: hardwired r0, a general write port, a dedicated
// rstatus write port, and two combinational read ports with write-to-read bypass.
module regfile_core
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_status_we,
    input  logic [DATA_W-1:0] i_status_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // NOTE: storage is reset on purpose so no register can ever read back as X;
    // this keeps the array out of RAM macros, which is acceptable at 32 entries.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make the later status write override
            // a same-cycle general write to r30 without any ordering hazards.
            if (i_we && (i_waddr != REG_ZERO)) begin
                r_regs[i_waddr] <= i_wdata;
            end
            if (i_status_we) begin
                r_regs[REG_STATUS] <= i_status_wdata;
            end
        end
    end

    // Bypass order mirrors the write priority: status port, then general port, then storage.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic              status_we,
        input logic [DATA_W-1:0] status_wdata
    );
        if (addr == REG_ZERO)                       return '0;
        else if (status_we && addr == REG_STATUS)   return status_wdata;
        else if (we && addr == waddr)               return wdata;
        else                                        return stored;
    endfunction

    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    assign w_stored_a = r_regs[i_raddr_a];
    assign w_stored_b = r_regs[i_raddr_b];

    assign o_rdata_a = bypass_read(i_raddr_a, w_stored_a, i_we, i_waddr, i_wdata,
                                   i_status_we, i_status_wdata);
    assign o_rdata_b = bypass_read(i_raddr_b, w_stored_b, i_we, i_waddr, i_wdata,
                                   i_status_we, i_status_wdata);

endmodule

// File: rtl/regfile_read_stage.sv
// Decode read stage: register file plus the D/X latch carrying operands and instruction.
// Latch priority is reset > flush > stall > load.
module regfile_read_stage
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_writeStatus,
    input  logic [DATA_W-1:0] data_writeStatusReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] insn_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic [DATA_W-1:0] insn_out,
    output logic              valid_out
);

    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    regfile_core u_core (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .i_we           (ctrl_writeEnable),
        .i_waddr        (ctrl_writeReg),
        .i_wdata        (data_writeReg),
        .i_status_we    (ctrl_writeStatus),
        .i_status_wdata (data_writeStatusReg),
        .i_raddr_a      (ctrl_readRegA),
        .i_raddr_b      (ctrl_readRegB),
        .o_rdata_a      (w_rdata_a),
        .o_rdata_b      (w_rdata_b)
    );

    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_insn;
    logic              r_valid;

    // A stalled latch keeps its operands even if their source register is rewritten.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_insn  <= INSN_NOP;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_insn  <= INSN_NOP;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_op_a  <= w_rdata_a;
            r_op_b  <= w_rdata_b;
            r_insn  <= insn_in;
            r_valid <= 1'b1;
        end
    end

    assign data_readRegA = r_op_a;
    assign data_readRegB = r_op_b;
    assign insn_out      = r_insn;
    assign valid_out     = r_valid;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: inputs change 1ns after a rising edge,
// outputs are compared 1ns after the following rising edge.
module tb_regfile_read_stage;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_writeStatus;
    logic [31:0] data_writeStatusReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] insn_in;
    logic        stall;
    logic        flush;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic [31:0] insn_out;
    logic        valid_out;

    int n_pass  = 0;
    int n_total = 0;

    regfile_read_stage dut (
        .clock               (clock),
        .ctrl_reset_n        (ctrl_reset_n),
        .ctrl_writeEnable    (ctrl_writeEnable),
        .ctrl_writeReg       (ctrl_writeReg),
        .data_writeReg       (data_writeReg),
        .ctrl_writeStatus    (ctrl_writeStatus),
        .data_writeStatusReg (data_writeStatusReg),
        .ctrl_readRegA       (ctrl_readRegA),
        .ctrl_readRegB       (ctrl_readRegB),
        .insn_in             (insn_in),
        .stall               (stall),
        .flush               (flush),
        .data_readRegA       (data_readRegA),
        .data_readRegB       (data_readRegB),
        .insn_out            (insn_out),
        .valid_out           (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_writeEnable    = 1'b0;
        ctrl_writeReg       = 5'd0;
        data_writeReg       = 32'h0;
        ctrl_writeStatus    = 1'b0;
        data_writeStatusReg = 32'h0;
        stall               = 1'b0;
        flush               = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        insn_in       = 32'h0;
        ctrl_reset_n  = 1'b0;
        tick();
        tick();
        n_total++;
        if ({data_readRegA, data_readRegB, insn_out, valid_out} !== 97'h0) begin
            $display("FAIL reset_initial: got A=%h B=%h insn=%h valid=%b, want all 0",
                     data_readRegA, data_readRegB, insn_out, valid_out);
        end else n_pass++;
        ctrl_reset_n = 1'b1;

        // Put non-zero state in the latch, then reset mid-cycle.
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h33;
        ctrl_readRegA    = 5'd3;
        insn_in          = 32'h1111;
        tick();
        n_total++;
        if (data_readRegA !== 32'h33 || insn_out !== 32'h1111 || valid_out !== 1'b1) begin
            $display("FAIL reset_preload: got A=%h insn=%h valid=%b, want 33 1111 1",
                     data_readRegA, insn_out, valid_out);
        end else n_pass++;

        #2 ctrl_reset_n = 1'b0;
        #1;
        n_total++;
        if (data_readRegA !== 32'h0 || insn_out !== 32'h0 || valid_out !== 1'b0) begin
            $display("FAIL reset_async: got A=%h insn=%h valid=%b, want 0 0 0",
                     data_readRegA, insn_out, valid_out);
        end else n_pass++;

        // A write strobed across an edge while reset is held must be lost.
        ctrl_writeReg = 5'd4;
        data_writeReg = 32'h44;
        @(posedge clock);
        #2 ctrl_reset_n = 1'b1;
        idle_inputs();
        tick();

        for (int i = 1; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(32 - i);
            tick();
            n_total++;
            if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
                $display("FAIL reset_clear_r%0d: got A=%h B=%h, want 0 0",
                         i, data_readRegA, data_readRegB);
            end else n_pass++;
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        ctrl_readRegA    = 5'd0;
        tick();
        idle_inputs();
        ctrl_readRegA = 5'd5;
        insn_in       = 32'h0000_0100;
        tick();
        n_total++;
        if (data_readRegA !== 32'hDEADBEEF || valid_out !== 1'b1 || insn_out !== 32'h100) begin
            $display("FAIL write_read: got A=%h valid=%b insn=%h, want deadbeef 1 100",
                     data_readRegA, valid_out, insn_out);
        end else n_pass++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h12345678;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd7;
        tick();
        n_total++;
        if (data_readRegB !== 32'h12345678 || data_readRegA !== 32'hDEADBEEF) begin
            $display("FAIL bypass_same_cycle: got A=%h B=%h, want deadbeef 12345678",
                     data_readRegA, data_readRegB);
        end else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (data_readRegB !== 32'h12345678) begin
            $display("FAIL bypass_stored: got B=%h, want 12345678", data_readRegB);
        end else n_pass++;
    endtask

    task automatic test_r0_status();
        idle_inputs();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFFFFFF;
        ctrl_readRegA    = 5'd0;
        tick();
        n_total++;
        if (data_readRegA !== 32'h0) begin
            $display("FAIL r0_no_bypass: got A=%h, want 0", data_readRegA);
        end else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (data_readRegA !== 32'h0) begin
            $display("FAIL r0_stored: got A=%h, want 0", data_readRegA);
        end else n_pass++;

        ctrl_writeEnable    = 1'b1;
        ctrl_writeReg       = 5'd30;
        data_writeReg       = 32'h5;
        ctrl_writeStatus    = 1'b1;
        data_writeStatusReg = 32'h1;
        ctrl_readRegB       = 5'd30;
        tick();
        n_total++;
        if (data_readRegB !== 32'h1) begin
            $display("FAIL status_bypass_prio: got B=%h, want 1", data_readRegB);
        end else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (data_readRegB !== 32'h1) begin
            $display("FAIL status_write_prio: got B=%h, want 1", data_readRegB);
        end else n_pass++;

        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd30;
        data_writeReg    = 32'h77;
        ctrl_readRegA    = 5'd30;
        tick();
        n_total++;
        if (data_readRegA !== 32'h77) begin
            $display("FAIL r30_normal_bypass: got A=%h, want 77", data_readRegA);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd7;
        insn_in       = 32'hABCD0001;
        tick();
        n_total++;
        if (insn_out !== 32'hABCD0001 || valid_out !== 1'b1 || data_readRegA !== 32'hDEADBEEF) begin
            $display("FAIL stall_load: got insn=%h valid=%b A=%h, want abcd0001 1 deadbeef",
                     insn_out, valid_out, data_readRegA);
        end else n_pass++;

        stall         = 1'b1;
        insn_in       = 32'hFFFF0000;
        ctrl_readRegA = 5'd7;
        tick();
        insn_in = 32'h12340000;
        tick();
        n_total++;
        if (insn_out !== 32'hABCD0001 || data_readRegA !== 32'hDEADBEEF ||
            data_readRegB !== 32'h12345678 || valid_out !== 1'b1) begin
            $display("FAIL stall_hold: got insn=%h A=%h B=%h valid=%b, want abcd0001 deadbeef 12345678 1",
                     insn_out, data_readRegA, data_readRegB, valid_out);
        end else n_pass++;

        flush = 1'b1;
        tick();
        n_total++;
        if (insn_out !== 32'h0 || valid_out !== 1'b0 ||
            data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
            $display("FAIL flush_over_stall: got insn=%h valid=%b A=%h B=%h, want 0 0 0 0",
                     insn_out, valid_out, data_readRegA, data_readRegB);
        end else n_pass++;

        flush = 1'b0;
        tick();
        n_total++;
        if (insn_out !== 32'h0 || valid_out !== 1'b0) begin
            $display("FAIL bubble_hold: got insn=%h valid=%b, want 0 0", insn_out, valid_out);
        end else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stall_write();
        idle_inputs();
        ctrl_readRegA = 5'd9;
        insn_in       = 32'h9000;
        tick();
        n_total++;
        if (data_readRegA !== 32'h0 || insn_out !== 32'h9000) begin
            $display("FAIL stall_write_pre: got A=%h insn=%h, want 0 9000", data_readRegA, insn_out);
        end else n_pass++;

        stall            = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h99;
        insn_in          = 32'h9999;
        tick();
        n_total++;
        if (data_readRegA !== 32'h0 || insn_out !== 32'h9000 || valid_out !== 1'b1) begin
            $display("FAIL stall_write_hold: got A=%h insn=%h valid=%b, want 0 9000 1",
                     data_readRegA, insn_out, valid_out);
        end else n_pass++;

        idle_inputs();
        insn_in = 32'h9001;
        tick();
        n_total++;
        if (data_readRegA !== 32'h99 || insn_out !== 32'h9001 || valid_out !== 1'b1) begin
            $display("FAIL stall_write_commit: got A=%h insn=%h valid=%b, want 99 9001 1",
                     data_readRegA, insn_out, valid_out);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0_status();
        test_stall_flush();
        test_stall_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
